// File: rtl/i2s_tx_stereo_pkg.sv
// ---------------------------------------------------------------------------
// i2s_tx_stereo_pkg
//   Shared constants and types for the stereo I2S transmitter.
//   - SYNTH_WIDTH / I2S_SAMPLE_WIDTH : native sample width of the audio source
//   - I2S_DEFAULT_SLOT_WIDTH         : default SCLK periods per channel slot
//   - I2S_DEFAULT_SCLK_DIV           : default clk_in cycles per SCLK period
//   - i2s_frame_t                    : one stereo frame at the native width
// ---------------------------------------------------------------------------
package i2s_tx_stereo_pkg;

    localparam int SYNTH_WIDTH            = 24;
    localparam int I2S_SAMPLE_WIDTH       = SYNTH_WIDTH;
    localparam int I2S_DEFAULT_SLOT_WIDTH = 24;
    localparam int I2S_DEFAULT_SCLK_DIV   = 16;

    typedef struct packed {
        logic [I2S_SAMPLE_WIDTH-1:0] left;
        logic [I2S_SAMPLE_WIDTH-1:0] right;
    } i2s_frame_t;

endpackage

// File: rtl/i2s_sclk_gen.sv
// ---------------------------------------------------------------------------
// i2s_sclk_gen
//   Divides clk_in down to the serial bit clock. SCLK is a registered output,
//   never used as a clock inside the design; consumers use the strobes.
//   Ports:
//     clk_in    in   MCLK-rate system clock
//     rst_in    in   asynchronous active-high reset
//     sclk_out  out  serial bit clock, low for the first half of each period
//     fall_tick out  high in the clk_in cycle that ends with the SCLK fall
// ---------------------------------------------------------------------------
module i2s_sclk_gen
    import i2s_tx_stereo_pkg::*;
#(
    parameter int SCLK_DIV = I2S_DEFAULT_SCLK_DIV
) (
    input  logic clk_in,
    input  logic rst_in,
    output logic sclk_out,
    output logic fall_tick
);

    localparam int              DIV_W    = $clog2(SCLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_RISE = DIV_W'(SCLK_DIV / 2 - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             rise_tick;

    // Strobes mark the last cycle before the corresponding SCLK edge, so
    // registers updated on the strobe change together with sclk_out.
    assign fall_tick = (div_cnt == DIV_LAST);
    assign rise_tick = (div_cnt == DIV_RISE);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            div_cnt  <= '0;
            sclk_out <= 1'b0;
        end else begin
            div_cnt <= fall_tick ? '0 : div_cnt + 1'b1;
            if (rise_tick) begin
                sclk_out <= 1'b1;
            end else if (fall_tick) begin
                sclk_out <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/i2s_tx_stereo.sv
// ---------------------------------------------------------------------------
// i2s_tx_stereo
//   Parametrised stereo I2S / left-justified transmitter, single clock domain.
//   Ports:
//     clk_in       in   MCLK-rate system clock
//     rst_in       in   asynchronous active-high reset
//     left_in      in   left sample, two's complement, MSB sent first
//     right_in     in   right sample
//     valid_in     in   left_in/right_in hold a frame
//     ready_out    out  holding register empty (frame taken on valid&&ready)
//     mute_in      in   send zeros; held frames are still consumed
//     mclk_out     out  clk_in pass-through
//     sclk_out     out  serial bit clock
//     lrck_out     out  word select, 0 = left slot, 1 = right slot
//     sdin_out     out  serial data, changes on SCLK falling edges
//     frame_out    out  one-cycle pulse per load event
//     underrun_out out  one-cycle pulse when a load finds no frame held
// ---------------------------------------------------------------------------
module i2s_tx_stereo
    import i2s_tx_stereo_pkg::*;
#(
    parameter int SAMPLE_WIDTH = I2S_SAMPLE_WIDTH,
    parameter int SLOT_WIDTH   = I2S_DEFAULT_SLOT_WIDTH,
    parameter int SCLK_DIV     = I2S_DEFAULT_SCLK_DIV,
    parameter bit I2S_MODE     = 1'b1
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic [SAMPLE_WIDTH-1:0] left_in,
    input  logic [SAMPLE_WIDTH-1:0] right_in,
    input  logic                    valid_in,
    output logic                    ready_out,
    input  logic                    mute_in,
    output logic                    mclk_out,
    output logic                    sclk_out,
    output logic                    lrck_out,
    output logic                    sdin_out,
    output logic                    frame_out,
    output logic                    underrun_out
);

    localparam int FRAME_BITS = 2 * SLOT_WIDTH;
    localparam int CNT_W      = $clog2(FRAME_BITS);
    localparam int PAD_BITS   = SLOT_WIDTH - SAMPLE_WIDTH;

    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0] RIGHT_CNT = CNT_W'(SLOT_WIDTH);
    // I2S delays the MSB by one SCLK, so the frame is loaded when bit_cnt
    // becomes 1; left-justified loads right at the LRCK edge.
    localparam logic [CNT_W-1:0] LOAD_CNT  = I2S_MODE ? CNT_W'(1) : '0;

    logic                    fall_tick;
    logic [CNT_W-1:0]        bit_cnt;
    logic [CNT_W-1:0]        bit_cnt_next;
    logic [SAMPLE_WIDTH-1:0] hold_left;
    logic [SAMPLE_WIDTH-1:0] hold_right;
    logic                    holding_full;
    logic [SLOT_WIDTH-1:0]   left_slot;
    logic [SLOT_WIDTH-1:0]   right_slot;
    logic [FRAME_BITS-1:0]   frame_word;
    logic [FRAME_BITS-1:0]   shift_reg;
    logic                    load;
    logic                    accept;

    assign mclk_out = clk_in;

    i2s_sclk_gen #(
        .SCLK_DIV (SCLK_DIV)
    ) u_sclk_gen (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .sclk_out  (sclk_out),
        .fall_tick (fall_tick)
    );

    // Gated with reset so the handshake is closed while the block is held.
    assign ready_out = !holding_full && !rst_in;
    assign sdin_out  = shift_reg[FRAME_BITS-1];

    // NOTE: every signal written here is assigned on every path, so no
    // latches are inferred.
    always_comb begin
        bit_cnt_next = (bit_cnt == LAST_CNT) ? '0 : bit_cnt + 1'b1;
        load         = fall_tick && (bit_cnt_next == LOAD_CNT);
        accept       = valid_in && ready_out;
        // Sample left-aligned in its slot; pad bits below the LSB are zero.
        left_slot    = SLOT_WIDTH'(hold_left) << PAD_BITS;
        right_slot   = SLOT_WIDTH'(hold_right) << PAD_BITS;
        frame_word   = (holding_full && !mute_in) ? {left_slot, right_slot} : '0;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            bit_cnt      <= '0;
            lrck_out     <= 1'b0;
            shift_reg    <= '0;
            // NOTE: the holding register is a handful of flops, not a RAM,
            // so clearing it in reset costs nothing and keeps it defined.
            hold_left    <= '0;
            hold_right   <= '0;
            holding_full <= 1'b0;
            frame_out    <= 1'b0;
            underrun_out <= 1'b0;
        end else begin
            frame_out    <= load;
            underrun_out <= load && !holding_full;

            if (fall_tick) begin
                bit_cnt   <= bit_cnt_next;
                lrck_out  <= (bit_cnt_next >= RIGHT_CNT);
                shift_reg <= load ? frame_word : {shift_reg[FRAME_BITS-2:0], 1'b0};
            end

            // A frame accepted on the load edge was not visible to that load
            // (frame_word used the pre-edge state), so it stays held.
            if (accept) begin
                hold_left    <= left_in;
                hold_right   <= right_in;
                holding_full <= 1'b1;
            end else if (load) begin
                holding_full <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx_stereo.sv
// ---------------------------------------------------------------------------
// tb_i2s_tx_stereo
//   Three transmitters share clk_in/rst: I2S 8/8, left-justified 8/8 and
//   I2S 6-in-8. Accepted frames go to a per-instance scoreboard; each
//   frame_out pops the expected word, and the following 16 SCLK rising
//   edges are compared against it together with the word-select pattern.
// ---------------------------------------------------------------------------
module tb_i2s_tx_stereo;

    localparam int NI   = 3;
    localparam int SLOT = 8;

    typedef struct {
        logic [15:0] word;
        longint      acc_cyc;
    } sb_entry_t;

    logic          clk_in = 1'b0;
    logic          rst    = 1'b1;
    logic [7:0]    left_a  [NI];
    logic [7:0]    right_a [NI];
    logic [NI-1:0] valid_v = '0;
    logic [NI-1:0] mute_v  = '0;
    logic [NI-1:0] mute_q  = '0;
    logic [NI-1:0] ready_v, mclk_v, sclk_v, lrck_v, sdin_v, frame_v, under_v;
    longint        cyc = 0;
    int            total = 0;
    int            bad = 0;
    sb_entry_t     sb_q [NI][$];

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) begin
        cyc    <= cyc + 1;
        mute_q <= mute_v;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic int sw_of(input int g);
        return (g == 2) ? 6 : 8;
    endfunction

    function automatic logic [15:0] exp_word_of(input int sw, input logic [7:0] l, input logic [7:0] r);
        logic [7:0] mask;
        mask = 8'hFF >> (8 - sw);
        return {(l & mask) << (8 - sw), (r & mask) << (8 - sw)};
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int          SW     = (g == 2) ? 6 : 8;
        localparam bit          MODE   = (g == 1) ? 1'b0 : 1'b1;
        localparam logic [15:0] LR_EXP = MODE ? 16'h01FE : 16'h00FF;

        i2s_tx_stereo #(
            .SAMPLE_WIDTH (SW),
            .SLOT_WIDTH   (SLOT),
            .SCLK_DIV     (4),
            .I2S_MODE     (MODE)
        ) dut (
            .clk_in       (clk_in),
            .rst_in       (rst),
            .left_in      (left_a[g][SW-1:0]),
            .right_in     (right_a[g][SW-1:0]),
            .valid_in     (valid_v[g]),
            .ready_out    (ready_v[g]),
            .mute_in      (mute_v[g]),
            .mclk_out     (mclk_v[g]),
            .sclk_out     (sclk_v[g]),
            .lrck_out     (lrck_v[g]),
            .sdin_out     (sdin_v[g]),
            .frame_out    (frame_v[g]),
            .underrun_out (under_v[g])
        );

        initial begin : mon
            logic        coll, prev_sclk, have_last;
            int          n;
            logic [15:0] cap, lr_cap, exp_word;
            longint      last_cyc;
            sb_entry_t   e;
            coll = 1'b0; prev_sclk = 1'b0; have_last = 1'b0;
            n = 0; cap = '0; lr_cap = '0; exp_word = '0; last_cyc = 0;
            forever begin
                @(negedge clk_in);
                if (rst) begin
                    coll      = 1'b0;
                    have_last = 1'b0;
                    prev_sclk = 1'b0;
                end else begin
                    if (sclk_v[g] && !prev_sclk && coll) begin
                        cap    = {cap[14:0], sdin_v[g]};
                        lr_cap = {lr_cap[14:0], lrck_v[g]};
                        n++;
                        if (n == 16) begin
                            check($sformatf("data[%0d]", g), cap, exp_word);
                            check($sformatf("lrck_pat[%0d]", g), lr_cap, LR_EXP);
                            coll = 1'b0;
                        end
                    end
                    prev_sclk = sclk_v[g];
                    if (under_v[g] && !frame_v[g])
                        check($sformatf("under_noload[%0d]", g), under_v[g], 1'b0);
                    if (frame_v[g]) begin
                        if (coll)
                            check($sformatf("frame_early[%0d]", g), n, 16);
                        if (have_last)
                            check($sformatf("period[%0d]", g), cyc - last_cyc, 64);
                        have_last = 1'b1;
                        last_cyc  = cyc;
                        if (sb_q[g].size() > 0 && sb_q[g][0].acc_cyc < cyc) begin
                            e        = sb_q[g].pop_front();
                            exp_word = mute_q[g] ? 16'h0000 : e.word;
                            check($sformatf("under[%0d]", g), under_v[g], 1'b0);
                        end else begin
                            exp_word = 16'h0000;
                            check($sformatf("under[%0d]", g), under_v[g], 1'b1);
                        end
                        coll = 1'b1; n = 0; cap = '0; lr_cap = '0;
                    end
                end
            end
        end
    end

    task automatic release_and_check();
        logic s, l;
        repeat (2) @(negedge clk_in);
        check("rst_outs", {sclk_v, lrck_v, sdin_v, frame_v, under_v, ready_v}, '0);
        rst = 1'b0;
        #1;
        check("ready_rel", ready_v, 3'b111);
        for (int k = 1; k <= 72; k++) begin
            @(negedge clk_in);
            s = ((k % 4) >= 2);
            l = (((k / 4) % 16) >= 8);
            check("sclk_lrck", {sclk_v, lrck_v}, {{3{s}}, {3{l}}});
        end
        check("mclk_lo", mclk_v, 3'b000);
        #6;
        check("mclk_hi", mclk_v, 3'b111);
    endtask

    task automatic send_frame(input logic [7:0] l, input logic [7:0] r);
        logic [NI-1:0] pend;
        int            guard;
        pend  = '1;
        guard = 0;
        for (int g = 0; g < NI; g++) begin
            left_a[g]  = l;
            right_a[g] = r;
        end
        @(negedge clk_in);
        while (pend != '0 && guard < 300) begin
            valid_v = pend;
            for (int g = 0; g < NI; g++) begin
                if (pend[g] && ready_v[g]) begin
                    sb_q[g].push_back('{word: exp_word_of(sw_of(g), l, r), acc_cyc: cyc + 1});
                    pend[g] = 1'b0;
                end
            end
            @(negedge clk_in);
            guard++;
        end
        valid_v = '0;
        if (pend != '0)
            check("send_timeout", pend, '0);
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((sb_q[0].size() + sb_q[1].size() + sb_q[2].size()) != 0 && n < budget) begin
            @(negedge clk_in);
            n++;
        end
        check("drain", sb_q[0].size() + sb_q[1].size() + sb_q[2].size(), 0);
    endtask

    task automatic wait_frame0();
        int n;
        n = 0;
        do begin
            @(negedge clk_in);
            n++;
        end while (!frame_v[0] && n < 100);
        check("frame0_wait", frame_v[0], 1'b1);
    endtask

    initial begin
        longint cyc0;
        int     n;
        for (int g = 0; g < NI; g++) begin
            left_a[g]  = '0;
            right_a[g] = '0;
        end

        // Reset, then SCLK/LRCK timing; early loads are underruns.
        release_and_check();

        // First frame, then a second one held while the register is full.
        send_frame(8'hA5, 8'h3C);
        check("ready_full", ready_v[0], 1'b0);
        send_frame(8'h5A, 8'hC3);
        n = 0;
        do begin
            @(negedge clk_in);
            n++;
        end while (!ready_v[0] && n < 100);
        check("ready_at_load", frame_v[0], 1'b1);

        send_frame(8'h80, 8'h01);
        send_frame(8'hFF, 8'h00);
        send_frame(8'h3F, 8'hC0);
        wait_drain(300);

        // Mute during a load: held frame consumed, zeros sent, no underrun.
        mute_v = '1;
        send_frame(8'h7E, 8'h81);
        wait_drain(200);
        mute_v = '0;

        // Idle for two frames: underrun every load.
        repeat (140) @(negedge clk_in);

        // Frame accepted on the very edge of an I2S load.
        wait_frame0();
        repeat (62) @(negedge clk_in);
        send_frame(8'hC6, 8'h39);
        wait_drain(200);

        // Reset mid-frame at bit_cnt = 5 with a second frame held.
        send_frame(8'h1F, 8'h2E);
        for (int i = 0; i < 3; i++) begin
            wait_frame0();
            if (!under_v[0]) break;
        end
        cyc0 = cyc;
        send_frame(8'h22, 8'h44);
        while (cyc < cyc0 + 16) @(negedge clk_in);
        check("sdin_pre", sdin_v[0], 1'b1);
        check("ready_pre", ready_v[0], 1'b0);
        #1 rst = 1'b1;
        #1 check("rst_async", {sclk_v, lrck_v, sdin_v, frame_v, under_v, ready_v}, '0);
        for (int g = 0; g < NI; g++) sb_q[g].delete();
        release_and_check();

        send_frame(8'h96, 8'h69);
        send_frame(8'h01, 8'h80);
        wait_drain(300);
        repeat (150) @(negedge clk_in);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
